ram_82s21_write_ctl: RTL
========================

// Module: ram_82s21_write_ctl
// PURPOSE
// - Write-side sequencer for an 82S21-style 32x2 RAM (write enables, WCLK_N, LATCH_N, CE).
// - Takes single-word write requests or a whole-array clear, and drives the RAM pins with
//   correct setup, strobe and hold timing in clock cycles.
// - Sits between microcode/datapath write logic and a part_82S21 instance.
// PARAMETERS
// - WCLK_PULSE  2  cycles WCLK_N is held low per write (legal 1..15)
// - READ_WAIT   1  cycles of read access before readback sample (verify only, legal 1..15)
// PORTS
// - clk          in   1  system clock, all state changes on posedge
// - reset        in   1  synchronous, active-high reset
// - req_valid    in   1  write request present
// - req_ready    out  1  controller can accept a request or clear (high only in IDLE)
// - req_addr     in   5  target word address
// - req_data     in   2  write data {D1,D0}
// - req_mask     in   2  per-bit write enable: bit0->WE0_N, bit1->WE1_N
// - clear_start  in   1  write 2'b00 to all 32 words (sampled only when req_ready)
// - busy         out  1  operation in progress (= ~req_ready)
// - done         out  1  one-cycle pulse when a write or full clear completes
// - err          out  1  readback mismatch, valid only with done (0 when VERIFY disabled)
// - ram_a        out  5  RAM address A4..A0
// - ram_i        out  2  RAM data-in I1,I0
// - ram_we0_n    out  1  bit-0 write enable, active low
// - ram_we1_n    out  1  bit-1 write enable, active low
// - ram_wclk_n   out  1  write clock, active low
// - ram_latch_n  out  1  output latch control, low = hold
// - ram_ce       out  1  chip enable, active high
// - ram_d        in   2  RAM data-out D1,D0 (readback)
// BEHAVIOUR
// - Reset values: req_ready=1 busy=0 done=0 err=0 ram_a=0 ram_i=0 ram_we0_n=1 ram_we1_n=1
//   ram_wclk_n=1 ram_latch_n=1 ram_ce=0. Reset mid-operation aborts at next edge, no done.
// - States: IDLE -> SETUP -> STROBE -> HOLD -> (VERIFY) -> IDLE.
// - IDLE: accept on req_ready & (clear_start | req_valid); clear_start wins if both high.
//   Registers addr/data/mask (clear: addr=0, data=00, mask=11).
// - SETUP (1 cyc): ram_ce=1, ram_a/ram_i driven, WE_N and WCLK_N high.
// - STROBE (WCLK_PULSE cyc): ram_wclk_n=0; ram_weN_n=~mask[N]; a/i/ce stable.
// - HOLD (1 cyc): WCLK_N and WE_N return high; a/i/ce still stable.
// - Mask 2'b00: full sequence runs, WE_N never low, done still pulses, err=0.
// - Single write latency: accept at edge T -> done high in cycle T+3+WCLK_PULSE (back in IDLE).
// - Clear: after HOLD, if addr!=31 increment addr and go to SETUP; addr 31 -> IDLE, one done.
//   Clear duration 32*(2+WCLK_PULSE) cycles + done cycle; no done per word.
// - done cycle is IDLE: req_ready=1, a new request may be accepted in that same cycle.
// - ram_ce drops to 0 in IDLE; ram_a/ram_i hold last value in IDLE.
// - ram_latch_n=1 (transparent) at all times except as stated under CONFIGURATION.
// CONFIGURATION
// - Macro RAM82S21_WRITE_VERIFY_EN.
// - Defined: HOLD -> VERIFY for READ_WAIT cycles (ce=1, WE_N/WCLK_N high, addr held);
//   ram_latch_n=0 in the last VERIFY cycle, ram_d sampled at its closing edge.
//   err=1 with done if (ram_d & mask) != (data & mask). Clear: err is OR over all 32 words.
//   Adds READ_WAIT cycles per word to latency.
// - Undefined: no VERIFY state, ram_d ignored, err tied 0, latencies as in BEHAVIOUR.
// TESTING
// - Reset then idle -> all outputs at reset values, req_ready=1, no done for 20 cycles.
// - req addr=5'h0A data=2'b10 mask=2'b11, WCLK_PULSE=2 -> a=0A i=10, we0_n=we1_n=0 and
//   wclk_n=0 exactly 2 cycles, done in cycle T+5, model word 0A reads 2'b10.
// - mask=2'b01 data=2'b11 over word holding 2'b00 -> only we0_n pulses, word reads 2'b01.
// - clear_start and req_valid same cycle -> clear runs, addresses 0..31 in order, one done
//   after 128 cycles (+1), request ignored; all 32 words read 2'b00.
// - Assert reset during STROBE of a write -> next cycle wclk_n=1 we*_n=1 ce=0, no done.
// - VERIFY_EN, model forces ram_d=2'b00 after writing 2'b11 mask 2'b10 -> done with err=1;
//   same with mask 2'b00 -> err=0.

Source files
------------

// File: rtl/ram_82s21_write_ctl.sv
// ram_82s21_write_ctl
// Write-side sequencer for an 82S21-style 32x2 RAM. Accepts single-word
// masked writes or a whole-array clear and sequences CE, address, data,
// WE0_N/WE1_N and WCLK_N through SETUP -> STROBE -> HOLD. All pin-facing
// outputs are registered, so the pins never glitch.
// Optional feature: define RAM82S21_WRITE_VERIFY_EN to add a VERIFY phase
// after HOLD that reads the word back through the output latch and reports
// any mismatch on err together with done.
module ram_82s21_write_ctl #(
  parameter int WCLK_PULSE = 2,  // cycles WCLK_N is low per write (1..15)
  parameter int READ_WAIT  = 1   // read access cycles before readback (1..15)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_addr,
  input  logic [1:0] req_data,
  input  logic [1:0] req_mask,
  input  logic       clear_start,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [4:0] ram_a,
  output logic [1:0] ram_i,
  output logic       ram_we0_n,
  output logic       ram_we1_n,
  output logic       ram_wclk_n,
  output logic       ram_latch_n,
  output logic       ram_ce,
  input  logic [1:0] ram_d
);

  localparam logic [3:0] PULSE_LAST = 4'(WCLK_PULSE - 1);

`ifdef RAM82S21_WRITE_VERIFY_EN
  localparam logic [3:0] WAIT_LAST = 4'(READ_WAIT - 1);
`else
  // Readback data and the read-wait setting have no use without VERIFY.
  logic unused_inputs;
  assign unused_inputs = ^{ram_d, 4'(READ_WAIT)};
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_STROBE = 3'd2,
`ifdef RAM82S21_WRITE_VERIFY_EN
    S_VERIFY = 3'd4,
`endif
    S_HOLD   = 3'd3
  } state_t;

  state_t     state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [4:0] addr, addr_nx;
  logic [1:0] data, data_nx;
  logic [1:0] mask, mask_nx;
  logic       clr, clr_nx;
  logic       err_acc, err_acc_nx;
  logic       done_nx, err_nx;
  logic       word_last, word_err;
  logic       latch_n_nx;

  // The RAM address and data pins come straight from the operand registers,
  // so they hold their last value while idle.
  assign ram_a = addr;
  assign ram_i = data;

  // Next-state, operand and completion logic for the write sequencer.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    addr_nx    = addr;
    data_nx    = data;
    mask_nx    = mask;
    clr_nx     = clr;
    err_acc_nx = err_acc;
    done_nx    = 1'b0;
    err_nx     = 1'b0;
    word_last  = 1'b0;
    word_err   = 1'b0;

    case (state)
      S_IDLE: begin
        // A clear takes priority over a simultaneous single-word request.
        if (clear_start) begin
          state_nx   = S_SETUP;
          addr_nx    = 5'd0;
          data_nx    = 2'b00;
          mask_nx    = 2'b11;
          clr_nx     = 1'b1;
          err_acc_nx = 1'b0;
        end else if (req_valid) begin
          state_nx   = S_SETUP;
          addr_nx    = req_addr;
          data_nx    = req_data;
          mask_nx    = req_mask;
          clr_nx     = 1'b0;
          err_acc_nx = 1'b0;
        end else begin
          state_nx = S_IDLE;
        end
      end
      S_SETUP: begin
        state_nx = S_STROBE;
        cnt_nx   = 4'd0;
      end
      S_STROBE: begin
        if (cnt == PULSE_LAST) begin
          state_nx = S_HOLD;
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      S_HOLD: begin
`ifdef RAM82S21_WRITE_VERIFY_EN
        state_nx = S_VERIFY;
        cnt_nx   = 4'd0;
`else
        word_last = 1'b1;
`endif
      end
`ifdef RAM82S21_WRITE_VERIFY_EN
      S_VERIFY: begin
        // Only bits that were actually written are compared.
        if (cnt == WAIT_LAST) begin
          word_last = 1'b1;
          word_err  = ((ram_d & mask) != (data & mask));
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
`endif
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // End of one word: step to the next word of a clear, or finish with a
    // single done pulse carrying the accumulated readback error.
    if (word_last) begin
      if (clr && (addr != 5'd31)) begin
        addr_nx    = addr + 5'd1;
        state_nx   = S_SETUP;
        err_acc_nx = err_acc | word_err;
      end else begin
        state_nx   = S_IDLE;
        done_nx    = 1'b1;
        err_nx     = err_acc | word_err;
        err_acc_nx = 1'b0;
      end
    end else begin
      done_nx = 1'b0;
    end
  end

  // Output latch goes to hold only in the last read-access cycle of VERIFY.
  always_comb begin
`ifdef RAM82S21_WRITE_VERIFY_EN
    if ((state_nx == S_VERIFY) && (cnt_nx == WAIT_LAST)) begin
      latch_n_nx = 1'b0;
    end else begin
      latch_n_nx = 1'b1;
    end
`else
    latch_n_nx = 1'b1;
`endif
  end

  // State, operand and registered pin outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= 4'd0;
      addr        <= 5'd0;
      data        <= 2'b00;
      mask        <= 2'b00;
      clr         <= 1'b0;
      err_acc     <= 1'b0;
      req_ready   <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      ram_we0_n   <= 1'b1;
      ram_we1_n   <= 1'b1;
      ram_wclk_n  <= 1'b1;
      ram_latch_n <= 1'b1;
      ram_ce      <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      addr        <= addr_nx;
      data        <= data_nx;
      mask        <= mask_nx;
      clr         <= clr_nx;
      err_acc     <= err_acc_nx;
      req_ready   <= (state_nx == S_IDLE);
      busy        <= (state_nx != S_IDLE);
      done        <= done_nx;
      err         <= err_nx;
      ram_we0_n   <= ~((state_nx == S_STROBE) & mask_nx[0]);
      ram_we1_n   <= ~((state_nx == S_STROBE) & mask_nx[1]);
      ram_wclk_n  <= (state_nx != S_STROBE);
      ram_latch_n <= latch_n_nx;
      ram_ce      <= (state_nx != S_IDLE);
    end
  end

endmodule
